// File: rtl/oric_ram_pkg.sv
// Shared types and default sizing for the Oric main-RAM controller.
package oric_ram_pkg;

   localparam int         ORIC_RAM_AW   = 16;
   localparam int         ORIC_RAM_DW   = 8;
   localparam logic [7:0] ORIC_RAM_FILL = 8'hFF;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      RUN   = 2'd1,
      LOAD  = 2'd2
   } oric_ram_state_e;

endpackage

// File: rtl/oric_spram.sv
// Single-port inferred block RAM: registered read, old data returned on a write.
module oric_spram #(
   parameter int AW = 16,
   parameter int DW = 8
) (
   input  logic          clk_sys,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] d,
   output logic [DW-1:0] q
);

   logic [DW-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk_sys) begin
      if (we)
         mem[addr] <= d;
      q <= mem[addr];
   end

endmodule

// File: rtl/oric_ram_ctrl.sv
// Oric main-RAM controller: power-on/OSD fill, host download port, CPU access.
// Define ORIC_RAM_PATTERN_EN to fill alternating FILL/~FILL blocks of 2^PAT_SHIFT words.
module oric_ram_ctrl
   import oric_ram_pkg::*;
#(
   parameter int            AW        = ORIC_RAM_AW,
   parameter int            DW        = ORIC_RAM_DW,
   parameter logic [DW-1:0] FILL      = DW'(ORIC_RAM_FILL),
   parameter int            PAT_SHIFT = 7
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic          clr_req,
   input  logic [AW-1:0] cpu_ad,
   input  logic [DW-1:0] cpu_d,
   input  logic          cpu_cs,
   input  logic          cpu_we,
   output logic [DW-1:0] cpu_q,
   input  logic          dl_active,
   input  logic          dl_wr,
   input  logic [AW-1:0] dl_addr,
   input  logic [DW-1:0] dl_data,
   input  logic [AW-1:0] dl_base,
   output logic          busy,
   output logic          dl_done,
   output logic [AW:0]   dl_count
);

   localparam logic [AW:0] CNT_MAX = {1'b1, {AW{1'b0}}};
   // cpu_q source: zero out of reset, FILL while clearing, RAM otherwise
   localparam logic [1:0]  Q_ZERO  = 2'd0;
   localparam logic [1:0]  Q_FILL  = 2'd1;
   localparam logic [1:0]  Q_RAM   = 2'd2;

   if (PAT_SHIFT >= AW) begin : g_pat_chk
      $error("oric_ram_ctrl: PAT_SHIFT must be below AW");
   end

   oric_ram_state_e state;
   logic [AW-1:0]   clr_addr;
   logic [1:0]      q_mode;
   logic [DW-1:0]   fill_val;
   logic [AW-1:0]   dl_wa;
   logic            ram_we;
   logic [AW-1:0]   ram_addr;
   logic [DW-1:0]   ram_d;
   logic [DW-1:0]   ram_q;

`ifdef ORIC_RAM_PATTERN_EN
   assign fill_val = clr_addr[PAT_SHIFT] ? ~FILL : FILL;
`else
   assign fill_val = FILL;
`endif

   assign dl_wa = dl_base + dl_addr;

   always_comb begin
      ram_we   = 1'b0;
      ram_addr = cpu_ad;
      ram_d    = cpu_d;
      case (state)
         CLEAR: begin
            ram_we   = 1'b1;
            ram_addr = clr_addr;
            ram_d    = fill_val;
         end
         RUN:  ram_we = cpu_cs & cpu_we;
         LOAD: if (dl_wr) begin
            ram_we   = 1'b1;
            ram_addr = dl_wa;
            ram_d    = dl_data;
         end
         default: ;
      endcase
      // a restart request suppresses any write in its cycle
      if (clr_req)
         ram_we = 1'b0;
   end

   oric_spram #(.AW(AW), .DW(DW)) u_ram (
      .clk_sys (clk_sys),
      .we      (ram_we),
      .addr    (ram_addr),
      .d       (ram_d),
      .q       (ram_q)
   );

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state    <= CLEAR;
         clr_addr <= '0;
         busy     <= 1'b1;
         dl_done  <= 1'b0;
         dl_count <= '0;
         q_mode   <= Q_ZERO;
      end else begin
         dl_done <= 1'b0;
         q_mode  <= (state == CLEAR) ? Q_FILL : Q_RAM;
         if (clr_req) begin
            state    <= CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
         end else begin
            case (state)
               CLEAR: begin
                  clr_addr <= clr_addr + AW'(1);
                  if (&clr_addr) begin
                     busy <= 1'b0;
                     if (dl_active) begin
                        state    <= LOAD;
                        dl_count <= '0;
                     end else begin
                        state <= RUN;
                     end
                  end
               end
               RUN: if (dl_active) begin
                  state    <= LOAD;
                  dl_count <= '0;
               end
               LOAD: begin
                  if (dl_wr && dl_count != CNT_MAX)
                     dl_count <= dl_count + (AW+1)'(1);
                  if (!dl_active) begin
                     state   <= RUN;
                     dl_done <= 1'b1;
                  end
               end
               default: state <= CLEAR;
            endcase
         end
      end
   end

   assign cpu_q = (q_mode == Q_FILL) ? FILL :
                  (q_mode == Q_RAM)  ? ram_q : '0;

endmodule

// File: tb/tb_oric_ram_ctrl.sv
// Randomised bench for oric_ram_ctrl (AW=8) against a cycle-level behavioural model.
module tb_oric_ram_ctrl;

   localparam int         AW   = 8;
   localparam int         DW   = 8;
   localparam logic [7:0] FILL = 8'hFF;
`ifdef ORIC_RAM_PATTERN_EN
   localparam bit PAT = 1'b1;
`else
   localparam bit PAT = 1'b0;
`endif
   localparam int S_CLEAR = 0, S_RUN = 1, S_LOAD = 2;

   logic       clk_sys = 1'b0, reset_n = 1'b0, clr_req = 1'b0;
   logic       cpu_cs = 1'b0, cpu_we = 1'b0, dl_active = 1'b0, dl_wr = 1'b0;
   logic [7:0] cpu_ad = '0, cpu_d = '0, dl_addr = '0, dl_data = '0, dl_base = '0;
   logic [7:0] cpu_q;
   logic       busy, dl_done;
   logic [8:0] dl_count;

   int vecs = 0, errs = 0, done_cnt = 0;

   oric_ram_ctrl #(.AW(AW), .DW(DW), .FILL(FILL), .PAT_SHIFT(4)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .clr_req(clr_req),
      .cpu_ad(cpu_ad), .cpu_d(cpu_d), .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_q(cpu_q),
      .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
      .dl_base(dl_base), .busy(busy), .dl_done(dl_done), .dl_count(dl_count)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int         m_state, m_pos, m_cnt;
   logic       m_busy, m_done, m_qk;
   logic [7:0] m_q;
   logic [7:0] m_mem [256];

   function automatic logic [7:0] fill_of(int a);
      return (PAT && ((a / 16) % 2 == 1)) ? ~FILL : FILL;
   endfunction

   always @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         m_state = S_CLEAR; m_pos = 0; m_busy = 1'b1; m_done = 1'b0;
         m_cnt = 0; m_q = 8'h00; m_qk = 1'b1;
      end else begin
         m_done = 1'b0;
         if (clr_req)                          m_qk = 1'b0;
         else if (m_state == S_CLEAR)          begin m_q = FILL; m_qk = 1'b1; end
         else if (m_state == S_LOAD && dl_wr)  m_qk = 1'b0;
         else                                  begin m_q = m_mem[cpu_ad]; m_qk = 1'b1; end
         if (clr_req) begin
            m_state = S_CLEAR; m_pos = 0; m_busy = 1'b1;
         end else if (m_state == S_CLEAR) begin
            m_mem[m_pos] = fill_of(m_pos);
            m_pos++;
            if (m_pos == 256) begin
               m_pos = 0; m_busy = 1'b0;
               m_state = dl_active ? S_LOAD : S_RUN;
               if (dl_active) m_cnt = 0;
            end
         end else if (m_state == S_RUN) begin
            if (cpu_cs && cpu_we) m_mem[cpu_ad] = cpu_d;
            if (dl_active) begin m_state = S_LOAD; m_cnt = 0; end
         end else begin
            if (dl_wr) begin
               m_mem[(int'(dl_base) + int'(dl_addr)) % 256] = dl_data;
               if (m_cnt < 256) m_cnt++;
            end
            if (!dl_active) begin m_state = S_RUN; m_done = 1'b1; end
         end
      end
   end

   always @(negedge clk_sys) begin
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("dl_done", {31'd0, dl_done}, {31'd0, m_done});
      chk("dl_count", {23'd0, dl_count}, m_cnt);
      if (m_qk) chk("cpu_q", {24'd0, cpu_q}, {24'd0, m_q});
      if (dl_done === 1'b1) done_cnt++;
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk_sys);
      #2;
   endtask

   task automatic idle();
      cpu_cs = 1'b0; cpu_we = 1'b0; dl_wr = 1'b0; clr_req = 1'b0;
   endtask

   task automatic wait_fill(output int n);
      n = 0;
      while (busy === 1'b1 && n < 400) begin step(); n++; end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_busy"}, {31'd0, busy}, 1);
      chk({tag, "_cpu_q"}, {24'd0, cpu_q}, 0);
      chk({tag, "_dl_done"}, {31'd0, dl_done}, 0);
      chk({tag, "_dl_count"}, {23'd0, dl_count}, 0);
   endtask

   initial begin
      int n, d0;
      logic [7:0] e;
      bit in_dl;

      repeat (3) step();
      check_reset_vals("rst");
      reset_n = 1'b1;
      wait_fill(n);
      chk("busy_len_reset", n, 256);

      // 1: fill sweep
      for (int a = 0; a < 256; a++) begin
         cpu_cs = 1'b1; cpu_ad = 8'(a); step();
         e = (PAT && (a & 16) != 0) ? 8'h00 : 8'hFF;
         chk("fill_sweep", {24'd0, cpu_q}, {24'd0, e});
      end

      // 2: CPU write/read, and write without chip select
      cpu_cs = 1'b1; cpu_we = 1'b1; cpu_ad = 8'h42; cpu_d = 8'hA5; step();
      cpu_we = 1'b0; step();
      chk("wr_rd_42", {24'd0, cpu_q}, 32'hA5);
      cpu_cs = 1'b0; cpu_we = 1'b1; cpu_d = 8'h00; step();
      cpu_cs = 1'b1; cpu_we = 1'b0; step();
      chk("nocs_42", {24'd0, cpu_q}, 32'hA5);

      // 3: wrapping download, CPU writes to 0x42 during LOAD must be dropped
      idle(); dl_base = 8'hF0; dl_active = 1'b1; d0 = done_cnt; step();
      chk("load_cnt0", {23'd0, dl_count}, 0);
      for (int i = 0; i < 20; i++) begin
         dl_wr = 1'b1; dl_addr = 8'(i); dl_data = 8'(i);
         cpu_cs = 1'b1; cpu_we = 1'b1; cpu_ad = 8'h42; cpu_d = 8'h5A;
         step();
      end
      idle();
      chk("dl_count20", {23'd0, dl_count}, 20);
      dl_active = 1'b0; step();
      chk("dl_done_hi", {31'd0, dl_done}, 1);
      step();
      chk("dl_done_lo", {31'd0, dl_done}, 0);
      chk("dl_done_once", done_cnt - d0, 1);
      for (int a = 0; a < 256; a++) begin
         cpu_cs = 1'b1; cpu_ad = 8'(a); step();
         if (a >= 8'hF0) chk("dl_hi", {24'd0, cpu_q}, a - 8'hF0);
         else if (a < 4) chk("dl_wrap", {24'd0, cpu_q}, a + 16);
         else if (a == 8'h42) chk("load_cpu_wr", {24'd0, cpu_q}, 32'hA5);
      end

      // 4+6: clr_req during download; strobes during fill ignored; LOAD re-entered
      idle(); dl_base = 8'h10; dl_active = 1'b1; d0 = done_cnt; step();
      for (int i = 0; i < 5; i++) begin
         dl_wr = 1'b1; dl_addr = 8'(i); dl_data = 8'(8'h77 + i); step();
      end
      dl_wr = 1'b0; clr_req = 1'b1; step();
      clr_req = 1'b0;
      chk("clr_busy_rise", {31'd0, busy}, 1);
      n = 0;
      while (busy === 1'b1 && n < 400) begin
         dl_wr = 1'($urandom); dl_addr = 8'($urandom); dl_data = 8'($urandom);
         step(); n++;
      end
      dl_wr = 1'b0;
      chk("busy_len_clr", n, 256);
      chk("dl_count_restart", {23'd0, dl_count}, 0);
      chk("no_abort_done", done_cnt - d0, 0);
      for (int i = 0; i < 3; i++) begin
         dl_wr = 1'b1; dl_addr = 8'(i); dl_data = 8'hC0; step();
      end
      dl_wr = 1'b0;
      chk("dl_count3", {23'd0, dl_count}, 3);
      dl_active = 1'b0; step();
      chk("dl_done_after_clr", {31'd0, dl_done}, 1);

      // 5: reset pulse mid-CLEAR at clr_addr 0x80
      clr_req = 1'b1; step(); clr_req = 1'b0;
      repeat (128) step();
      reset_n = 1'b0; #1;
      check_reset_vals("midclr_rst");
      step();
      reset_n = 1'b1;
      wait_fill(n);
      chk("busy_len_rerun", n, 256);

      // dl_count saturates at 2^AW
      dl_active = 1'b1; step();
      for (int i = 0; i < 260; i++) begin
         dl_wr = 1'b1; dl_addr = 8'($urandom); dl_data = 8'($urandom); step();
      end
      dl_wr = 1'b0;
      chk("dl_count_sat", {23'd0, dl_count}, 256);
      dl_active = 1'b0; step();

      // random traffic
      in_dl = 1'b0;
      for (int c = 0; c < 1500; c++) begin
         cpu_cs = 1'($urandom); cpu_we = ($urandom_range(0, 2) == 0);
         cpu_ad = 8'($urandom); cpu_d = 8'($urandom);
         dl_addr = 8'($urandom); dl_data = 8'($urandom);
         if (!in_dl) begin
            dl_wr = 1'b0;
            if ($urandom_range(0, 39) == 0) begin
               in_dl = 1'b1; dl_active = 1'b1; dl_base = 8'($urandom);
            end
         end else begin
            dl_wr = 1'($urandom);
            if ($urandom_range(0, 19) == 0) begin in_dl = 1'b0; dl_active = 1'b0; end
         end
         step();
      end
      idle(); dl_active = 1'b0; step(); step();
      for (int a = 0; a < 256; a++) begin
         cpu_cs = 1'b1; cpu_ad = 8'(a); step();
      end
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
